gmm_bg_count_pipe: RTL and testbench



---
 rtl/gmm_bg_count_pipe.sv | 153 +++++++++++++++
 tb/tb_gmm_bg_count_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmm_bg_count_pipe.sv
// Two-stage cumulative-weight / background-count stage ahead of the GMM foreground detector.
// Optional saturating background-pixel counter enabled by defining GMM_BG_COUNT_STATS_EN.
package gmm_bg_count_pkg;

    typedef struct packed {
        logic [7:0] pixel;
        logic [2:0] clusters_num;
    } in_t;

    typedef struct packed {
        in_t              in;
        logic [2:0][7:0]  mem_w;
        logic [2:0][7:0]  mem_mu;
        logic [2:0][15:0] vars;
        logic [7:0]       var_lr;
        logic [2:0][18:0] w_sum;
        logic [1:0]       B;
        logic [2:0]       is_matched;
        logic [1:0]       p_max_idx;
    } mega_data_t;

endpackage

module gmm_bg_count_pipe
    import gmm_bg_count_pkg::*;
#(
    parameter logic [7:0] T_BG = 8'd179
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snk_valid,
    input  mega_data_t  snk_data,
    output logic        snk_ready,
    input  logic        src_ready,
    output logic        src_valid,
    output mega_data_t  src_data,
    output logic [31:0] stat_bg_cnt
);

    logic       s1_valid_reg;
    mega_data_t s1_data_reg;
    mega_data_t s1_data_next;
    logic       s2_valid_reg;
    mega_data_t s2_data_reg;
    mega_data_t s2_data_next;
    logic       s1_ready;
    logic       s2_ready;
    logic       s1_load;
    logic       s2_load;

    assign s2_ready  = src_ready | ~s2_valid_reg;
    assign s1_ready  = s2_ready | ~s1_valid_reg;
    assign s1_load   = snk_valid & s1_ready;
    assign s2_load   = s1_valid_reg & s2_ready;
    assign snk_ready = s1_ready;
    assign src_valid = s2_valid_reg;
    assign src_data  = s2_data_reg;

    // Masked per-cluster weights and their running sum; inactive clusters read as 0.
    logic [18:0] term [3];
    logic [18:0] acc  [3];
    logic [2:0][18:0] w_sum_next;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_acc
            logic active;
            assign active   = (3'(gi) < snk_data.in.clusters_num);
            assign term[gi] = active ? {11'b0, snk_data.mem_w[gi]} : 19'd0;
            if (gi == 0) begin : g_first
                assign acc[gi] = term[gi];
            end else begin : g_rest
                assign acc[gi] = acc[gi-1] + term[gi];
            end
            assign w_sum_next[gi] = active ? acc[gi] : 19'd0;
        end
    endgenerate

    always_comb begin
        s1_data_next       = snk_data;
        s1_data_next.w_sum = w_sum_next;
    end

    logic [1:0]  n_clusters;
    logic [18:0] t_ext;
    logic [1:0]  b_next;

    assign n_clusters = (s1_data_reg.in.clusters_num > 3'd3) ? 2'd3
                                                             : s1_data_reg.in.clusters_num[1:0];
    assign t_ext = {11'b0, T_BG};

    // First b whose prefix sum strictly exceeds the threshold, else n.
    always_comb begin
        b_next = n_clusters;
        if (n_clusters == 2'd0) begin
            b_next = 2'd0;
        end else if (s1_data_reg.w_sum[0] > t_ext) begin
            b_next = 2'd1;
        end else if (n_clusters >= 2'd2 && s1_data_reg.w_sum[1] > t_ext) begin
            b_next = 2'd2;
        end else if (n_clusters == 2'd3 && s1_data_reg.w_sum[2] > t_ext) begin
            b_next = 2'd3;
        end
    end

    always_comb begin
        s2_data_next   = s1_data_reg;
        s2_data_next.B = b_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= s1_data_next;
            end else if (s2_ready) begin
                s1_valid_reg <= 1'b0;
            end
            if (s2_load) begin
                s2_valid_reg <= 1'b1;
                s2_data_reg  <= s2_data_next;
            end else if (src_ready) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

`ifdef GMM_BG_COUNT_STATS_EN
    logic [31:0] bg_cnt_reg;
    logic        bg_hit;

    assign bg_hit = s2_valid_reg & src_ready & (s2_data_reg.B == 2'd1)
                  & (s2_data_reg.in.clusters_num != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_cnt_reg <= 32'd0;
        end else if (bg_hit && bg_cnt_reg != 32'hFFFF_FFFF) begin
            bg_cnt_reg <= bg_cnt_reg + 32'd1;
        end
    end

    assign stat_bg_cnt = bg_cnt_reg;
`else
    assign stat_bg_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_gmm_bg_count_pipe.sv
// Directed bench for gmm_bg_count_pipe: latency, threshold boundaries, backpressure,
// reset mid-stall and the optional stats counter.
module tb_gmm_bg_count_pipe;
    import gmm_bg_count_pkg::*;

`ifdef GMM_BG_COUNT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snk_valid = 1'b0;
    mega_data_t  snk_data = '0;
    logic        snk_ready;
    logic        src_ready = 1'b0;
    logic        src_valid;
    mega_data_t  src_data;
    logic [31:0] stat_bg_cnt;

    int vectors = 0;
    int miscompares = 0;

    gmm_bg_count_pipe #(.T_BG(8'd179)) dut (
        .clk(clk), .rst(rst),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .src_ready(src_ready), .src_valid(src_valid), .src_data(src_data),
        .stat_bg_cnt(stat_bg_cnt)
    );

    always #5 clk = ~clk;

    function automatic mega_data_t mk(input logic [2:0] cn, input logic [7:0] w0,
                                      input logic [7:0] w1, input logic [7:0] w2,
                                      input logic [7:0] tag);
        mega_data_t d;
        d.in.pixel        = tag;
        d.in.clusters_num = cn;
        d.mem_w           = {w2, w1, w0};
        d.mem_mu          = {tag ^ 8'h5A, tag + 8'd3, ~tag};
        d.vars            = {{tag, 8'h11}, {8'h22, tag}, {tag, tag}};
        d.var_lr          = ~tag;
        d.w_sum           = {3{19'h7FFFF}};
        d.B               = 2'b11;
        d.is_matched      = tag[2:0];
        d.p_max_idx       = tag[4:3];
        return d;
    endfunction

    // Reference model written as a plain loop over clusters.
    function automatic mega_data_t model(input mega_data_t d);
        mega_data_t r;
        int n, sum, b;
        r = d;
        n = (d.in.clusters_num > 3) ? 3 : int'(d.in.clusters_num);
        sum = 0;
        b = -1;
        for (int k = 0; k < 3; k++) begin
            if (k < n) begin
                sum += int'(d.mem_w[k]);
                r.w_sum[k] = 19'(sum);
                if (b < 0 && sum > 179) b = k + 1;
            end else begin
                r.w_sum[k] = 19'd0;
            end
        end
        r.B = (b < 0) ? 2'(n) : 2'(b);
        return r;
    endfunction

    // Drive one record into an empty pipe and return what emerges two cycles later.
    task automatic one_record(input string name, input mega_data_t rec, output mega_data_t out);
        @(negedge clk);
        snk_valid = 1'b1; snk_data = rec; src_ready = 1'b1;
        #1;
        vectors++;
        if (snk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s snk_ready got %b want 1", name, snk_ready);
        end
        @(negedge clk);
        snk_valid = 1'b0;
        #1;
        vectors++;
        if (src_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early src_valid got %b want 0", name, src_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (src_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s latency src_valid got %b want 1", name, src_valid);
        end
        out = src_data;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (src_valid !== 1'b0 || snk_ready !== 1'b1 || stat_bg_cnt !== 32'd0 ||
            src_data.w_sum !== '0 || src_data.B !== 2'd0) begin
            miscompares++;
            $display("FAIL reset valid=%b ready=%b cnt=%0d wsum=%h B=%0d want 0 1 0 0 0",
                     src_valid, snk_ready, stat_bg_cnt, src_data.w_sum, src_data.B);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        mega_data_t in, out, want;
        in = mk(3'd3, 8'd200, 8'd40, 8'd15, 8'h31);
        one_record("basic", in, out);
        want = in;
        want.w_sum = {19'd255, 19'd240, 19'd200};
        want.B = 2'd1;
        vectors++;
        if (out !== want) begin
            miscompares++;
            $display("FAIL basic got wsum=%h B=%0d want wsum=%h B=1 (or passthrough)",
                     out.w_sum, out.B, want.w_sum);
        end
        $display("basic: B=%0d w_sum=%0d/%0d/%0d", out.B, out.w_sum[0], out.w_sum[1], out.w_sum[2]);
    endtask

    task automatic test_threshold;
        mega_data_t out;
        one_record("thr_eq", mk(3'd3, 8'd100, 8'd79, 8'd76, 8'h42), out);
        vectors++;
        if (out.B !== 2'd3 || out.w_sum !== {19'd255, 19'd179, 19'd100}) begin
            miscompares++;
            $display("FAIL thr_eq got B=%0d wsum=%h want B=3", out.B, out.w_sum);
        end
        $display("thr_eq: B=%0d", out.B);
        one_record("thr_gt", mk(3'd3, 8'd100, 8'd80, 8'd75, 8'h43), out);
        vectors++;
        if (out.B !== 2'd2 || out.w_sum[1] !== 19'd180) begin
            miscompares++;
            $display("FAIL thr_gt got B=%0d w1=%0d want B=2 w1=180", out.B, out.w_sum[1]);
        end
        $display("thr_gt: B=%0d", out.B);
    endtask

    task automatic test_partial_empty;
        mega_data_t out;
        one_record("partial", mk(3'd2, 8'd90, 8'd60, 8'd255, 8'h54), out);
        vectors++;
        if (out.B !== 2'd2 || out.w_sum !== {19'd0, 19'd150, 19'd90}) begin
            miscompares++;
            $display("FAIL partial got B=%0d wsum=%h want B=2 wsum=0/150/90", out.B, out.w_sum);
        end
        $display("partial: B=%0d", out.B);
        one_record("empty", mk(3'd0, 8'd200, 8'd200, 8'd200, 8'h65), out);
        vectors++;
        if (out.B !== 2'd0 || out.w_sum !== '0) begin
            miscompares++;
            $display("FAIL empty got B=%0d wsum=%h want 0 0", out.B, out.w_sum);
        end
        $display("empty: B=%0d", out.B);
        one_record("cn7", mk(3'd7, 8'd10, 8'd10, 8'd10, 8'h66), out);
        vectors++;
        if (out.B !== 2'd3 || out.w_sum !== {19'd30, 19'd20, 19'd10}) begin
            miscompares++;
            $display("FAIL cn7 got B=%0d wsum=%h want B=3 wsum=30/20/10", out.B, out.w_sum);
        end
    endtask

    task automatic test_backpressure;
        mega_data_t sent [6];
        mega_data_t held;
        int sidx, ridx;
        bit was_stalled, exp_ready;
        sent[0] = mk(3'd3, 8'd200, 8'd40, 8'd15, 8'h81);
        sent[1] = mk(3'd3, 8'd100, 8'd79, 8'd76, 8'h82);
        sent[2] = mk(3'd2, 8'd90, 8'd60, 8'd255, 8'h83);
        sent[3] = mk(3'd0, 8'd1, 8'd2, 8'd3, 8'h84);
        sent[4] = mk(3'd3, 8'd100, 8'd80, 8'd75, 8'h85);
        sent[5] = mk(3'd1, 8'd20, 8'd0, 8'd0, 8'h86);
        sidx = 0; ridx = 0; was_stalled = 1'b0; held = '0;
        for (int t = 0; t < 60 && ridx < 6; t++) begin
            @(negedge clk);
            src_ready = !(t >= 3 && t <= 7);
            snk_valid = (sidx < 6);
            snk_data  = sent[(sidx < 6) ? sidx : 5];
            #1;
            exp_ready = !((sidx - ridx) == 2 && !src_ready);
            vectors++;
            if (snk_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL bp_ready t=%0d got %b want %b", t, snk_ready, exp_ready);
            end
            if (was_stalled) begin
                vectors++;
                if (src_valid !== 1'b1 || src_data !== held) begin
                    miscompares++;
                    $display("FAIL bp_hold t=%0d valid=%b data changed", t, src_valid);
                end
            end
            if (src_valid && src_ready) begin
                vectors++;
                if (src_data !== model(sent[ridx])) begin
                    miscompares++;
                    $display("FAIL bp_data rec=%0d got pix=%h B=%0d want pix=%h B=%0d", ridx,
                             src_data.in.pixel, src_data.B, sent[ridx].in.pixel, model(sent[ridx]).B);
                end
                $display("bp: out rec %0d pix=%h B=%0d", ridx, src_data.in.pixel, src_data.B);
                ridx++;
            end
            was_stalled = src_valid && !src_ready;
            held = src_data;
            if (snk_valid && snk_ready) sidx++;
        end
        @(negedge clk);
        snk_valid = 1'b0; src_ready = 1'b1;
        #1;
        vectors++;
        if (ridx != 6 || src_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_count got %0d recs extra_valid=%b want 6 0", ridx, src_valid);
        end
    endtask

    task automatic test_reset_stall;
        @(negedge clk);
        src_ready = 1'b0; snk_valid = 1'b1; snk_data = mk(3'd3, 8'd200, 8'd0, 8'd0, 8'h91);
        @(negedge clk);
        snk_data = mk(3'd3, 8'd10, 8'd10, 8'd10, 8'h92);
        @(negedge clk);
        snk_valid = 1'b0;
        #1;
        vectors++;
        if (src_valid !== 1'b1 || snk_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stall_fill valid=%b ready=%b want 1 0", src_valid, snk_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (src_valid !== 1'b0 || snk_ready !== 1'b1 || src_data.w_sum !== '0 ||
            src_data.B !== 2'd0 || stat_bg_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_stall valid=%b ready=%b B=%0d cnt=%0d want 0 1 0 0",
                     src_valid, snk_ready, src_data.B, stat_bg_cnt);
        end
        @(negedge clk);
        rst = 1'b0; src_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (src_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_stale t=%0d src_valid got %b want 0", t, src_valid);
            end
        end
        $display("reset mid-stall: pipe empty afterwards");
    endtask

    task automatic test_stats;
        mega_data_t recs [10];
        int sidx, got;
        recs[0] = mk(3'd3, 8'd200, 8'd10, 8'd10, 8'hA0);
        recs[1] = mk(3'd3, 8'd100, 8'd50, 8'd50, 8'hA1);
        recs[2] = mk(3'd1, 8'd180, 8'd0, 8'd0, 8'hA2);
        recs[3] = mk(3'd0, 8'd200, 8'd0, 8'd0, 8'hA3);
        recs[4] = mk(3'd2, 8'd100, 8'd100, 8'd0, 8'hA4);
        recs[5] = mk(3'd2, 8'd255, 8'd0, 8'd0, 8'hA5);
        recs[6] = mk(3'd3, 8'd179, 8'd0, 8'd0, 8'hA6);
        recs[7] = mk(3'd2, 8'd10, 8'd10, 8'd0, 8'hA7);
        recs[8] = mk(3'd3, 8'd190, 8'd5, 8'd5, 8'hA8);
        recs[9] = mk(3'd3, 8'd90, 8'd90, 8'd90, 8'hA9);
        sidx = 0; got = 0;
        for (int t = 0; t < 40 && got < 10; t++) begin
            @(negedge clk);
            src_ready = 1'b1;
            snk_valid = (sidx < 10);
            snk_data  = recs[(sidx < 10) ? sidx : 9];
            #1;
            if (src_valid) got++;
            if (snk_valid && snk_ready) sidx++;
        end
        @(negedge clk);
        snk_valid = 1'b0;
        #1;
        vectors++;
        if (got != 10 || stat_bg_cnt !== (STATS ? 32'd4 : 32'd0)) begin
            miscompares++;
            $display("FAIL stats_10 got cnt=%0d recs=%0d want cnt=%0d recs=10",
                     stat_bg_cnt, got, STATS ? 4 : 0);
        end
        $display("stats: cnt=%0d after 10 records", stat_bg_cnt);
        @(negedge clk);
        src_ready = 1'b0; snk_valid = 1'b1; snk_data = mk(3'd3, 8'd250, 8'd0, 8'd0, 8'hB0);
        @(negedge clk);
        snk_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (src_valid !== 1'b1 || stat_bg_cnt !== (STATS ? 32'd4 : 32'd0)) begin
            miscompares++;
            $display("FAIL stats_stall valid=%b cnt=%0d want 1 %0d", src_valid, stat_bg_cnt, STATS ? 4 : 0);
        end
        @(negedge clk);
        src_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (src_valid !== 1'b0 || stat_bg_cnt !== (STATS ? 32'd5 : 32'd0)) begin
            miscompares++;
            $display("FAIL stats_release valid=%b cnt=%0d want 0 %0d", src_valid, stat_bg_cnt, STATS ? 5 : 0);
        end
        $display("stats: cnt=%0d after stalled handshake", stat_bg_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_partial_empty();
        test_backpressure();
        test_reset_stall();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
